fpu_issue_arbiter: RTL and testbench

- Shares one pipelined recoded-float FMA unit and one recFN-to-FN convert unit between two requesters (integer-side issue port 0, load/store-side port 1).
- Performs round-robin arbitration and tracks in-flight ops with tags.
- Reserves the single shared writeback slot so ops of different latency never collide.
- Sits between the issue stage and the hardfloat datapath wrappers.

---
 rtl/fpu_issue_arbiter_pkg.sv | 21 ++
 rtl/fpu_issue_arbiter_if.sv | 23 ++
 rtl/fpu_issue_arbiter_slot_tracker.sv | 67 ++++++
 rtl/fpu_issue_arbiter.sv | 128 ++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared types and constants for the two-port FPU issue arbiter.
// Tag width is fixed here because the in-flight entry struct carries it.
package fpu_arb_pkg;

    localparam int FMA_LAT_DEF = 4;
    localparam int CVT_LAT_DEF = 1;
    localparam int TAG_W       = 5;
    localparam int REC_W       = 33;
    localparam int FN_W        = 32;

    localparam logic FPU_OP_FMA = 1'b0;
    localparam logic FPU_OP_CVT = 1'b1;

    typedef struct packed {
        logic             valid;
        logic             port;
        logic [TAG_W-1:0] tag;
        logic             op;
    } fpu_inflight_t;

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Request bundle between the two issue ports and the FPU arbiter.
interface fpu_issue_arbiter_if;
    import fpu_arb_pkg::*;

    logic [1:0]                  IN_req_valid;
    logic [1:0]                  IN_req_op;
    logic [1:0][REC_W-1:0]       IN_req_a;
    logic [1:0][REC_W-1:0]       IN_req_b;
    logic [1:0][REC_W-1:0]       IN_req_c;
    logic [1:0][TAG_W-1:0]       IN_req_tag;
    logic [1:0]                  OUT_req_ready;

    modport master (
        output IN_req_valid, IN_req_op, IN_req_a, IN_req_b, IN_req_c, IN_req_tag,
        input  OUT_req_ready
    );

    modport slave (
        input  IN_req_valid, IN_req_op, IN_req_a, IN_req_b, IN_req_c, IN_req_tag,
        output OUT_req_ready
    );

endinterface

// File: rtl/fpu_issue_arbiter_slot_tracker.sv
// Writeback-slot reservation shift register and in-flight entry pipeline.
// Stage s of the pipeline holds the op whose result arrives s cycles from now.
module fpu_wb_slot_tracker
    import fpu_arb_pkg::*;
#(
    parameter int FMA_LAT = FMA_LAT_DEF,
    parameter int CVT_LAT = CVT_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                issue_i,
    input  fpu_inflight_t       issue_ent_i,
    output logic                fma_ok_o,
    output logic                cvt_ok_o,
    output fpu_inflight_t       head_o,
    output logic [FMA_LAT-1:0]  valid_o
);

    logic [FMA_LAT:1]            res_q, res_d;
    fpu_inflight_t [FMA_LAT-1:0] ent_q, ent_d;
    int                          lat;

    always_comb begin
        lat   = (issue_ent_i.op == FPU_OP_CVT) ? CVT_LAT : FMA_LAT;
        res_d = {1'b0, res_q[FMA_LAT:2]};
        ent_d = '0;
        for (int s = 0; s < FMA_LAT - 1; s++) begin
            ent_d[s] = ent_q[s + 1];
        end
        // New reservation lands after the shift, so it is indexed one lower.
        if (issue_i) begin
            for (int k = 1; k <= FMA_LAT; k++) begin
                if (k == lat - 1) res_d[k] = 1'b1;
            end
            for (int s = 0; s < FMA_LAT; s++) begin
                if (s == lat - 1) ent_d[s] = issue_ent_i;
            end
        end
        if (flush_i) begin
            res_d = '0;
            ent_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            ent_q <= '0;
        end else begin
            res_q <= res_d;
            ent_q <= ent_d;
        end
    end

    assign fma_ok_o = !res_q[FMA_LAT];
    assign cvt_ok_o = !res_q[CVT_LAT];
    assign head_o   = ent_q[0];

    always_comb begin
        valid_o = '0;
        for (int s = 0; s < FMA_LAT; s++) begin
            valid_o[s] = ent_q[s].valid;
        end
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue of two requesters onto shared FMA/convert units with one writeback slot.
// Optional macro FPU_ARB_PERF_EN adds issued / slot-stall / flushed counters.
module fpu_issue_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int FMA_LAT = FMA_LAT_DEF,
    parameter int CVT_LAT = CVT_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_issue_arbiter_if.slave req,
    input  logic               IN_flush,
    output logic               OUT_fma_valid,
    output logic [REC_W-1:0]   OUT_fma_a,
    output logic [REC_W-1:0]   OUT_fma_b,
    output logic [REC_W-1:0]   OUT_fma_c,
    output logic               OUT_cvt_valid,
    output logic [REC_W-1:0]   OUT_cvt_a,
    input  logic [REC_W-1:0]   IN_fma_res,
    input  logic [FN_W-1:0]    IN_cvt_res,
    output logic               OUT_wb_valid,
    output logic               OUT_wb_port,
    output logic [TAG_W-1:0]   OUT_wb_tag,
    output logic [REC_W-1:0]   OUT_wb_data,
    output logic               OUT_busy
`ifdef FPU_ARB_PERF_EN
    ,
    output logic [31:0]        OUT_perf_issued,
    output logic [31:0]        OUT_perf_slot_stall,
    output logic [31:0]        OUT_perf_flushed
`endif
);

    logic                fma_ok, cvt_ok;
    logic [1:0]          elig, gnt;
    logic                xfer, gnt_port, gnt_op;
    logic                last_grant_q, last_grant_d;
    fpu_inflight_t       issue_ent, head;
    logic [FMA_LAT-1:0]  trk_valid;
    logic                wb_valid_q, wb_port_q;
    logic [TAG_W-1:0]    wb_tag_q;
    logic [REC_W-1:0]    wb_data_q;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            elig[p] = req.IN_req_valid[p] &&
                      ((req.IN_req_op[p] == FPU_OP_CVT) ? cvt_ok : fma_ok);
        end
        if (&elig) gnt = last_grant_q ? 2'b01 : 2'b10;
        else       gnt = elig;
    end

    assign req.OUT_req_ready = (rst_n && !IN_flush) ? gnt : 2'b00;
    assign xfer     = |req.OUT_req_ready;
    assign gnt_port = req.OUT_req_ready[1];
    assign gnt_op   = req.IN_req_op[gnt_port];

    assign OUT_fma_valid = xfer && (gnt_op == FPU_OP_FMA);
    assign OUT_cvt_valid = xfer && (gnt_op == FPU_OP_CVT);
    assign OUT_fma_a     = req.IN_req_a[gnt_port];
    assign OUT_fma_b     = req.IN_req_b[gnt_port];
    assign OUT_fma_c     = req.IN_req_c[gnt_port];
    assign OUT_cvt_a     = req.IN_req_a[gnt_port];

    assign issue_ent    = '{valid: 1'b1, port: gnt_port, tag: req.IN_req_tag[gnt_port], op: gnt_op};
    assign last_grant_d = xfer ? gnt_port : last_grant_q;

    fpu_wb_slot_tracker #(
        .FMA_LAT (FMA_LAT),
        .CVT_LAT (CVT_LAT)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (IN_flush),
        .issue_i     (xfer),
        .issue_ent_i (issue_ent),
        .fma_ok_o    (fma_ok),
        .cvt_ok_o    (cvt_ok),
        .head_o      (head),
        .valid_o     (trk_valid)
    );

    // A result arriving in the flush cycle belongs to a killed op and is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            wb_valid_q   <= 1'b0;
            wb_port_q    <= 1'b0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_valid_q   <= head.valid && !IN_flush;
            if (head.valid && !IN_flush) begin
                wb_port_q <= head.port;
                wb_tag_q  <= head.tag;
                wb_data_q <= (head.op == FPU_OP_CVT) ? {1'b0, IN_cvt_res} : IN_fma_res;
            end
        end
    end

    assign OUT_wb_valid = wb_valid_q;
    assign OUT_wb_port  = wb_port_q;
    assign OUT_wb_tag   = wb_tag_q;
    assign OUT_wb_data  = wb_data_q;
    assign OUT_busy     = |trk_valid;

`ifdef FPU_ARB_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q, perf_flushed_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_stall_q   <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (xfer) perf_issued_q <= perf_issued_q + 32'd1;
            if (|req.IN_req_valid && !xfer) perf_stall_q <= perf_stall_q + 32'd1;
            if (IN_flush) perf_flushed_q <= perf_flushed_q + 32'($countones(trk_valid));
        end
    end

    assign OUT_perf_issued     = perf_issued_q;
    assign OUT_perf_slot_stall = perf_stall_q;
    assign OUT_perf_flushed    = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed self-checking bench for fpu_issue_arbiter with behavioural FMA/convert stand-ins.
module tb_fpu_issue_arbiter;
    import fpu_arb_pkg::*;

    localparam int FL = 4;

    logic        clk, rst_n, IN_flush;
    logic        OUT_fma_valid, OUT_cvt_valid;
    logic [32:0] OUT_fma_a, OUT_fma_b, OUT_fma_c, OUT_cvt_a;
    logic [32:0] IN_fma_res;
    logic [31:0] IN_cvt_res;
    logic        OUT_wb_valid, OUT_wb_port, OUT_busy;
    logic [4:0]  OUT_wb_tag;
    logic [32:0] OUT_wb_data;
`ifdef FPU_ARB_PERF_EN
    logic [31:0] perf_issued, perf_stall, perf_flushed;
`endif

    int checks = 0;
    int failures = 0;
    int n0, n1, j;

    logic [FL-1:0][32:0] fpipe;
    logic [31:0]         cvt_q;

    fpu_issue_arbiter_if bus ();

    fpu_issue_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (bus),
        .IN_flush      (IN_flush),
        .OUT_fma_valid (OUT_fma_valid),
        .OUT_fma_a     (OUT_fma_a),
        .OUT_fma_b     (OUT_fma_b),
        .OUT_fma_c     (OUT_fma_c),
        .OUT_cvt_valid (OUT_cvt_valid),
        .OUT_cvt_a     (OUT_cvt_a),
        .IN_fma_res    (IN_fma_res),
        .IN_cvt_res    (IN_cvt_res),
        .OUT_wb_valid  (OUT_wb_valid),
        .OUT_wb_port   (OUT_wb_port),
        .OUT_wb_tag    (OUT_wb_tag),
        .OUT_wb_data   (OUT_wb_data),
        .OUT_busy      (OUT_busy)
`ifdef FPU_ARB_PERF_EN
        ,
        .OUT_perf_issued     (perf_issued),
        .OUT_perf_slot_stall (perf_stall),
        .OUT_perf_flushed    (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] fma_f(input logic [32:0] a, input logic [32:0] b, input logic [32:0] c);
        return a ^ {b[31:0], 1'b0} ^ c;
    endfunction

    function automatic logic [31:0] cvt_f(input logic [32:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [32:0] cvt_opnd(input int t);
        return 33'h1_0000_0100 + 33'(t);
    endfunction

    function automatic logic [32:0] cvt_exp(input int t);
        return {1'b0, (32'h0000_0100 + 32'(t)) ^ 32'hA5A5_0000};
    endfunction

    // Fixed-latency datapath stand-ins feeding results back to the arbiter.
    always @(posedge clk) begin
        fpipe <= {fpipe[FL-2:0], OUT_fma_valid ? fma_f(OUT_fma_a, OUT_fma_b, OUT_fma_c) : 33'h0_5A5A_5A5A};
        cvt_q <= OUT_cvt_valid ? cvt_f(OUT_cvt_a) : 32'h3C3C_3C3C;
    end
    assign IN_fma_res = fpipe[FL-1];
    assign IN_cvt_res = cvt_q;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic chk_wb(input string nm, input logic v, input logic p, input int t, input logic [32:0] d);
        chk({nm, "_wbv"}, 64'(OUT_wb_valid), 64'(v));
        if (v) begin
            chk({nm, "_wbport"}, 64'(OUT_wb_port), 64'(p));
            chk({nm, "_wbtag"},  64'(OUT_wb_tag),  64'(t));
            chk({nm, "_wbdata"}, 64'(OUT_wb_data), 64'(d));
        end
    endtask

    task automatic idle();
        bus.IN_req_valid = 2'b00;
        bus.IN_req_op    = 2'b00;
        bus.IN_req_a     = '0;
        bus.IN_req_b     = '0;
        bus.IN_req_c     = '0;
        bus.IN_req_tag   = '0;
    endtask

    task automatic drive(input logic p, input logic op, input int t,
                         input logic [32:0] a, input logic [32:0] b, input logic [32:0] c);
        bus.IN_req_valid[p] = 1'b1;
        bus.IN_req_op[p]    = op;
        bus.IN_req_tag[p]   = 5'(t);
        bus.IN_req_a[p]     = a;
        bus.IN_req_b[p]     = b;
        bus.IN_req_c[p]     = c;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        IN_flush = 1'b0;
        idle();
        nxt();
        rst_n = 1'b1;
    endtask

    localparam logic [32:0] A1 = 33'h1_2345_6789;
    localparam logic [32:0] B1 = 33'h0_0F0F_0F0F;
    localparam logic [32:0] C1 = 33'h0_0000_00FF;

    initial begin
        // Reset with requests pending: nothing may be accepted or issued.
        rst_n    = 1'b0;
        IN_flush = 1'b0;
        idle();
        drive(1'b0, FPU_OP_FMA, 1, A1, B1, C1);
        drive(1'b1, FPU_OP_CVT, 2, A1, B1, C1);
        nxt();
        #2;
        chk("rst_ready", 64'(bus.OUT_req_ready), 64'd0);
        chk("rst_fma_v", 64'(OUT_fma_valid), 64'd0);
        chk("rst_cvt_v", 64'(OUT_cvt_valid), 64'd0);
        nxt();
        rst_n = 1'b1;
        idle();
        #2;
        chk("rst_wbv",    64'(OUT_wb_valid), 64'd0);
        chk("rst_wbport", 64'(OUT_wb_port),  64'd0);
        chk("rst_wbtag",  64'(OUT_wb_tag),   64'd0);
        chk("rst_wbdata", 64'(OUT_wb_data),  64'd0);
        chk("rst_busy",   64'(OUT_busy),     64'd0);
        nxt();

        // Single FMA from port 0: writeback FMA_LAT+1 cycles later.
        drive(1'b0, FPU_OP_FMA, 3, A1, B1, C1);
        #2;
        chk("fma1_ready", 64'(bus.OUT_req_ready), 64'b01);
        chk("fma1_fmav",  64'(OUT_fma_valid), 64'd1);
        chk("fma1_cvtv",  64'(OUT_cvt_valid), 64'd0);
        chk("fma1_a",     64'(OUT_fma_a), 64'(A1));
        chk("fma1_c",     64'(OUT_fma_c), 64'(C1));
        nxt();
        idle();
        for (int k = 1; k <= 5; k++) begin
            #2;
            if (k == 1) chk("fma1_busy", 64'(OUT_busy), 64'd1);
            if (k == 5) chk("fma1_idle", 64'(OUT_busy), 64'd0);
            chk_wb("fma1", k == 5, 1'b0, 3, fma_f(A1, B1, C1));
            nxt();
        end

        // Both ports stream CVTs: grants alternate, writebacks 2 cycles after issue.
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            if (n0 < 3) drive(1'b0, FPU_OP_CVT, 10 + n0, cvt_opnd(10 + n0), '0, '0);
            if (n1 < 3) drive(1'b1, FPU_OP_CVT, 20 + n1, cvt_opnd(20 + n1), '0, '0);
            #2;
            if (k < 6) chk("rr_ready", 64'(bus.OUT_req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k >= 2) begin
                j = k - 2;
                chk_wb("rr", 1'b1, 1'(j % 2), (j % 2 == 1) ? 20 + j / 2 : 10 + j / 2,
                       cvt_exp((j % 2 == 1) ? 20 + j / 2 : 10 + j / 2));
            end else begin
                chk_wb("rr_early", 1'b0, 1'b0, 0, '0);
            end
            if (bus.OUT_req_ready[0]) n0++;
            if (bus.OUT_req_ready[1]) n1++;
            nxt();
        end

        // FMA at 0 and CVT at 3 target the same slot: the CVT slips one cycle.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k == 0) drive(1'b0, FPU_OP_FMA, 1, A1, B1, C1);
            if (k == 3 || k == 4) drive(1'b1, FPU_OP_CVT, 2, cvt_opnd(2), '0, '0);
            #2;
            if (k == 0) chk("col_fma_ready", 64'(bus.OUT_req_ready), 64'b01);
            if (k == 3) begin
                chk("col_blk_ready", 64'(bus.OUT_req_ready), 64'b00);
                chk("col_blk_cvtv",  64'(OUT_cvt_valid), 64'd0);
            end
            if (k == 4) begin
                chk("col_cvt_ready", 64'(bus.OUT_req_ready), 64'b10);
                chk("col_cvt_v",     64'(OUT_cvt_valid), 64'd1);
                chk("col_cvt_a",     64'(OUT_cvt_a), 64'(cvt_opnd(2)));
            end
            if (k == 5)      chk_wb("col_fma", 1'b1, 1'b0, 1, fma_f(A1, B1, C1));
            else if (k == 6) chk_wb("col_cvt", 1'b1, 1'b1, 2, cvt_exp(2));
            else             chk_wb("col_none", 1'b0, 1'b0, 0, '0);
            nxt();
        end
`ifdef FPU_ARB_PERF_EN
        chk("perf_col_issued",  64'(perf_issued),  64'd2);
        chk("perf_col_stall",   64'(perf_stall),   64'd1);
        chk("perf_col_flushed", 64'(perf_flushed), 64'd0);
`endif

        // Two FMAs in flight are flushed; a later CVT issues and writes back normally.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            idle();
            IN_flush = (k == 2);
            if (k == 0) drive(1'b0, FPU_OP_FMA, 4, A1, B1, C1);
            if (k == 1) drive(1'b0, FPU_OP_FMA, 5, B1, C1, A1);
            if (k == 2 || k == 3) drive(1'b1, FPU_OP_CVT, 6, cvt_opnd(6), '0, '0);
            #2;
            if (k < 2) chk("fl_ready", 64'(bus.OUT_req_ready), 64'b01);
            if (k == 2) begin
                chk("fl_blk_ready", 64'(bus.OUT_req_ready), 64'b00);
                chk("fl_blk_cvtv",  64'(OUT_cvt_valid), 64'd0);
                chk("fl_busy",      64'(OUT_busy), 64'd1);
            end
            if (k == 3) begin
                chk("fl_after_busy",  64'(OUT_busy), 64'd0);
                chk("fl_after_ready", 64'(bus.OUT_req_ready), 64'b10);
            end
            if (k >= 2) chk_wb("fl", k == 5, 1'b1, 6, cvt_exp(6));
            nxt();
        end
        IN_flush = 1'b0;
`ifdef FPU_ARB_PERF_EN
        chk("perf_fl_issued",  64'(perf_issued),  64'd3);
        chk("perf_fl_stall",   64'(perf_stall),   64'd1);
        chk("perf_fl_flushed", 64'(perf_flushed), 64'd2);
`endif

        // Reset with three FMAs in flight: nothing writes back, port 0 wins afterwards.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            idle();
            rst_n = (k != 3);
            if (k == 0) drive(1'b0, FPU_OP_FMA, 7, A1, B1, C1);
            if (k == 1) drive(1'b1, FPU_OP_FMA, 8, A1, B1, C1);
            if (k == 2) drive(1'b0, FPU_OP_FMA, 9, A1, B1, C1);
            if (k == 3 || k == 4) begin
                drive(1'b0, FPU_OP_FMA, 10, A1, B1, C1);
                drive(1'b1, FPU_OP_FMA, 11, A1, B1, C1);
            end
            #2;
            if (k == 0 || k == 2) chk("mr_ready_p0", 64'(bus.OUT_req_ready), 64'b01);
            if (k == 1) chk("mr_ready_p1", 64'(bus.OUT_req_ready), 64'b10);
            if (k == 3) begin
                chk("mr_rst_ready", 64'(bus.OUT_req_ready), 64'b00);
                chk("mr_rst_fmav",  64'(OUT_fma_valid), 64'd0);
                chk("mr_rst_busy",  64'(OUT_busy), 64'd1);
            end
            if (k == 4) begin
                chk("mr_post_busy",  64'(OUT_busy), 64'd0);
                chk("mr_post_ready", 64'(bus.OUT_req_ready), 64'b01);
            end
            if (k >= 3) chk_wb("mr", 1'b0, 1'b0, 0, '0);
            nxt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
